spi_master_drv: RTL
===================

# spi_master_drv

Synthesizable SPI master that drives the SPI-slave/RAM subsystem over its four-wire link, the initiator end of the same 10-bit command frame the slave decodes.
- A parallel command port accepts one RAM operation at a time: write address, write data, read address or read data.
- The block serializes the frame on MOSI under SS_n, and for read-data collects the 8-bit reply from MISO.
- It sits in the testbench/top level as the stimulus source, and in integration as the host-side bridge. SCK is `clk` itself (same clock as the slave).

## Interface
- `RD_WAIT`, 2: idle cycles between the last MOSI bit of a read-data frame and the first MISO sample; legal 0..15.
- `clk`  in  1  system clock, also the SPI bit clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE; transfer when both high on a posedge.
- `cmd_op`  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- `cmd_data`  in  8  address or data byte; don't-care for rd-data.
- `rd_valid`  out  1  one-cycle pulse, read byte available.
- `rd_data`  out  8  read byte; held until the next rd_valid.
- `busy`  out  1  high in every state except IDLE.
- `ss_n`  out  1  slave select, active low, registered.
- `mosi`  out  1  serial data to slave, registered.
- `miso`  in  1  serial data from slave.

## Operation
- **Reset values:** state IDLE, `ss_n`=1, `mosi`=0, `cmd_ready`=1, `busy`=0, `rd_valid`=0, `rd_data`=8'h00, all counters 0.
- **States:** IDLE, SEND, WAIT, RECV, GAP.
- **IDLE:** `ss_n`=1, `mosi`=0. On accept, latch the 11-bit frame F = {cmd_op[1], cmd_op[1:0], cmd_data[7:0]}, then go to SEND. Bit F[10] is the slave's routing bit (0 write path, 1 read path).
- **SEND:**
  - 11 cycles, `ss_n`=0, `mosi` = F[10] down to F[0], MSB first, one bit per cycle.
  - After bit F[0]: if op==11, go to WAIT (or directly to RECV when RD_WAIT==0); otherwise go to GAP.
- **WAIT:** RD_WAIT cycles, `ss_n`=0, `mosi`=0, `miso` ignored.
- **RECV:**
  - 8 cycles, `ss_n`=0, `mosi`=0.
  - `miso` is sampled at the posedge ending each RECV cycle and shifted in MSB first.
  - Then go to GAP.
- **GAP:** 1 cycle, `ss_n`=1, `cmd_ready`=0. On a read-data frame, `rd_data` updates and `rd_valid`=1 for this cycle only. Then go to IDLE.
- **Input sampling:** `cmd_op`/`cmd_data` are sampled only at accept; later changes have no effect on the frame in flight.
- **cmd_valid while busy:** ignored (cmd_ready=0). It is not queued.
- **rst mid-frame:** `ss_n` rises to 1 immediately (asynchronously). The frame is dropped, and no `rd_valid` is issued for it.
- **Idle activity:** `miso` toggling outside RECV has no effect on any output.

## Timing
- Accept at edge T0.
- **Frame start:** `ss_n`=0 and `mosi`=F[10] from T0 to T1.
- **Frame end:** F[0] occupies T10 to T11.
- **Non-read ops:**
  - GAP T11 to T12, IDLE from T12.
  - Command-to-command spacing is 12 cycles.
- **Read-data:**
  - WAIT from T11 to T11+RD_WAIT.
  - RECV next 8 cycles, final sample at edge T19+RD_WAIT.
  - GAP with `rd_valid`=1 from T19+RD_WAIT to T20+RD_WAIT.
  - Spacing is 20+RD_WAIT cycles; 22 at default.
- **Register state:** `ss_n` and `mosi` are register outputs; no combinational path from `cmd_*` or `miso`.
- `cmd_ready` and `busy` are decoded from state only.

## Configuration
- **`SPI_MASTER_ASSERT_EN` defined:** concurrent assertions are compiled in, each with a matching cover:
  - `ss_n` is high on the cycle after reset deasserts.
  - `ss_n` stays low continuously for exactly 11 cycles on non-read frames and 19+RD_WAIT cycles on read-data frames.
  - `rd_valid` is never high for two consecutive cycles.
  - `rd_valid` only follows an accepted op 11.
  - `cmd_ready` and `busy` are never both high.
- **Not defined:** no assertion or cover code is present. RTL function is identical either way.

## Test plan
- **Reset:** assert `rst` mid-SEND of a wr-addr frame.
  - `ss_n` goes to 1 the same cycle; all outputs take reset values.
  - No `rd_valid`; the next command is accepted normally after deassert.
- **Write address:** cmd_op=00, cmd_data=8'hA5.
  - MOSI stream 0,0,0,1,0,1,0,0,1,0,1 over 11 low `ss_n` cycles.
  - `ss_n`=1 at T11; `cmd_ready`=1 at T12.
- **Write then read-address:** wr-data 8'h3C, then rd-addr 8'h3C, back to back with `cmd_valid` held high.
  - Second frame starts with F[10]=1, at T12 after the first accept.
  - Its stream is 1,1,0,0,0,1,1,1,1,0,0.
- **Read data:** rd-data with RD_WAIT=2; `miso` drives 8'h96 MSB first during the RECV cycles.
  - `rd_valid` is a single pulse 21 cycles after accept, with `rd_data`=8'h96.
  - `ss_n` is low for exactly 21 cycles.
- **Busy:** pulse `cmd_valid` with op=01 while a read-data frame is in RECV.
  - The command is ignored; no extra frame on MOSI.
  - `rd_data` is unaffected.
- **RD_WAIT=0:** rd-data; RECV begins right after F[0].
  - `rd_valid` is high 19 cycles after accept.
  - `miso` toggled during SEND has no effect.

Source files
------------

// File: rtl/spi_master_drv.sv
// spi_master_drv: SPI master serializing 11-bit RAM command frames and collecting read-data replies.
// Define SPI_MASTER_ASSERT_EN to compile in protocol assertions and covers.
module spi_master_drv #(
  parameter int RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAP} state_t;
  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT == 0 ? 0 : RD_WAIT - 1);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [10:0] frame;
  logic [7:0] rx;
  logic is_rd;
  logic accept;
  logic recv_done;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign recv_done = state == RECV && state_n == GAP;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = cmd_valid ? SEND : IDLE;
      SEND: state_n = cnt != 4'd10 ? SEND : !is_rd ? GAP : RD_WAIT == 0 ? RECV : WAIT;
      WAIT: state_n = cnt == WAIT_LAST ? RECV : WAIT;
      RECV: state_n = cnt == 4'd7 ? GAP : RECV;
      default: state_n = IDLE;
    endcase
  end
  // mosi/ss_n are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      frame <= 11'd0;
      rx <= 8'd0;
      is_rd <= 1'b0;
      ss_n <= 1'b1;
      mosi <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= 8'd0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || state == IDLE) ? 4'd0 : cnt + 4'd1;
      if (accept) begin
        frame <= {cmd_op[1], cmd_op, cmd_data};
        is_rd <= &cmd_op;
      end else if (state == SEND) begin
        frame <= {frame[9:0], 1'b0};
      end
      rx <= state == RECV ? {rx[6:0], miso} : rx;
      ss_n <= !(state_n == SEND || state_n == WAIT || state_n == RECV);
      mosi <= state_n != SEND ? 1'b0 : state == IDLE ? cmd_op[1] : frame[9];
      rd_valid <= recv_done;
      rd_data <= recv_done ? {rx[6:0], miso} : rd_data;
    end
  end
`ifdef SPI_MASTER_ASSERT_EN
  localparam int RD_LEN = 19 + RD_WAIT;
  a_rst_ss: assert property (@(posedge clk) $fell(rst) |-> ss_n);
  c_rst_ss: cover property (@(posedge clk) $fell(rst) ##0 ss_n);
  a_wr_len: assert property (@(posedge clk) disable iff (rst) $fell(ss_n) && !is_rd |-> !ss_n [*11] ##1 ss_n);
  c_wr_len: cover property (@(posedge clk) disable iff (rst) $fell(ss_n) && !is_rd ##0 !ss_n [*11] ##1 ss_n);
  a_rd_len: assert property (@(posedge clk) disable iff (rst) $fell(ss_n) && is_rd |-> !ss_n [*RD_LEN] ##1 ss_n);
  c_rd_len: cover property (@(posedge clk) disable iff (rst) $fell(ss_n) && is_rd ##0 !ss_n [*RD_LEN] ##1 ss_n);
  a_rv_single: assert property (@(posedge clk) disable iff (rst) rd_valid |=> !rd_valid);
  c_rv_single: cover property (@(posedge clk) disable iff (rst) rd_valid ##1 !rd_valid);
  a_rv_src: assert property (@(posedge clk) disable iff (rst) rd_valid |-> is_rd);
  c_rv_src: cover property (@(posedge clk) disable iff (rst) rd_valid && is_rd);
  a_excl: assert property (@(posedge clk) !(cmd_ready && busy));
  c_excl: cover property (@(posedge clk) cmd_ready && !busy);
`endif
endmodule
